// File: rtl/irqc_pkg.sv
// irqc_pkg: register map, CPU phase encoding and sizing shared by the interrupt controller.
package irqc_pkg;

    typedef enum logic [1:0] {
        IRQC_MASK = 2'd0,
        IRQC_PEND = 2'd1,
        IRQC_VEC  = 2'd2,
        IRQC_EOI  = 2'd3
    } irqc_reg_e;

    localparam int IRQC_NSRC_MAX = 16;
    localparam int IRQC_ID_W = $clog2(IRQC_NSRC_MAX);
    localparam logic [1:0] PHASE_FETCH = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set request index wins.
module irq_prio_enc
    import irqc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]      req,
    output logic [IRQC_ID_W-1:0] id,
    output logic                 any
);

    assign any = |req;

    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) id = IRQC_ID_W'(i);
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt controller with a register window.
// Define IRQC_SYNC_EN to put a 2-flop synchronizer in front of each source's edge detector.
module irq_controller
    import irqc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src,
    input  logic [1:0]      phase,
    input  logic            ien,
    output logic            irq,
    input  logic [1:0]      addr,
    input  logic            rd_mem,
    input  logic            wr_mem,
    input  logic [15:0]     wdata,
    output logic [15:0]     rdata
);

    logic [NSRC-1:0]      src_s, src_q, rise, pend, mask, req, w1c, acc_clr;
    logic [IRQC_ID_W-1:0] id, cur_id;
    logic                 any, insvc, accept, unused_ok;

`ifdef IRQC_SYNC_EN
    logic [NSRC-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = src;
`endif

    assign rise = src_s & ~src_q;
    assign req  = pend & mask;

    irq_prio_enc #(.NSRC(NSRC)) u_enc (
        .req (req),
        .id  (id),
        .any (any)
    );

    // Driven only from flops so the CPU never sees a glitch from src.
    assign irq     = ien & ~insvc & any;
    assign accept  = irq & (phase == PHASE_FETCH);
    assign w1c     = (wr_mem && addr == IRQC_PEND) ? wdata[NSRC-1:0] : '0;
    assign acc_clr = accept ? NSRC'(1) << id : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            pend   <= '0;
            mask   <= '0;
            insvc  <= 1'b0;
            cur_id <= '0;
        end else begin
            src_q <= src_s;
            pend  <= (pend & ~w1c & ~acc_clr) | rise;
            if (wr_mem && addr == IRQC_MASK)
                mask <= wdata[NSRC-1:0];
            if (accept) begin
                insvc  <= 1'b1;
                cur_id <= id;
            end else if (wr_mem && addr == IRQC_EOI)
                insvc <= 1'b0;
        end
    end

    assign rdata = !rd_mem             ? '0 :
                   addr == IRQC_MASK   ? 16'(mask) :
                   addr == IRQC_PEND   ? 16'(pend) :
                   addr == IRQC_VEC    ? {insvc, 11'b0, cur_id} : '0;

    assign unused_ok = &{1'b0, wdata};

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_irq_controller;
    import irqc_pkg::*;

`ifdef IRQC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 0, rst_n = 0, ien = 0, irq;
    logic [7:0]  src = 0;
    logic [1:0]  phase = 0, addr = 0;
    logic        rd_mem = 0, wr_mem = 0, chk = 0;
    logic [15:0] wdata = 0, rdata;

    typedef struct {
        bit          is_rd;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] act;
    int          n_tests = 0, n_fail = 0;

    irq_controller #(.NSRC(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .src    (src),
        .phase  (phase),
        .ien    (ien),
        .irq    (irq),
        .addr   (addr),
        .rd_mem (rd_mem),
        .wr_mem (wr_mem),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    // Monitor: every probe cycle consumes exactly one queued expectation.
    always @(negedge clk) begin
        if (rd_mem || chk) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL probe_without_expectation: rd_mem=%b chk=%b", rd_mem, chk);
            end else begin
                e = q.pop_front();
                act = e.is_rd ? rdata : {15'b0, irq};
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_mem = 0;
        wr_mem = 0;
        chk = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        addr = a;
        wdata = d;
        wr_mem = 1;
        tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] x, input string name);
        addr = a;
        rd_mem = 1;
        q.push_back('{1'b1, x, name});
        tick();
    endtask

    task automatic ck_irq(input logic x, input string name);
        chk = 1;
        q.push_back('{1'b0, {15'b0, x}, name});
        tick();
    endtask

    task automatic pulse(input logic [7:0] s);
        src = s;
        tick();
        src = 0;
        ticks(LAT);
    endtask

    task automatic fetch();
        phase = 2'd3;
        tick();
        phase = 2'd0;
    endtask

    initial begin
        tick();
        ck_irq(0, "reset_irq");
        rd(IRQC_MASK, 16'h0000, "reset_mask");
        rd(IRQC_PEND, 16'h0000, "reset_pend");
        rd(IRQC_VEC,  16'h0000, "reset_vec");
        rst_n = 1;
        tick();

        wr(IRQC_MASK, 16'h0005);
        ien = 1;
        src = 8'h04;
        tick();
        src = 0;
        for (int k = 0; k < LAT; k++) ck_irq(0, "sync_latency_low");
        ck_irq(1, "t1_irq_high");
        rd(IRQC_PEND, 16'h0004, "t1_pend");
        fetch();
        ck_irq(0, "t1_irq_after_accept");
        rd(IRQC_VEC,  16'h8002, "t1_vec");
        rd(IRQC_PEND, 16'h0000, "t1_pend_cleared");
        wr(IRQC_EOI, 16'h0000);

        wr(IRQC_MASK, 16'h00FF);
        pulse(8'h22);
        ck_irq(1, "t2_irq_two_pending");
        fetch();
        rd(IRQC_VEC, 16'h8001, "t2_vec_low_first");
        wr(IRQC_EOI, 16'h0000);
        ck_irq(1, "t2_irq_after_eoi");
        fetch();
        rd(IRQC_VEC,  16'h8005, "t2_vec_second");
        rd(IRQC_PEND, 16'h0000, "t2_pend_empty");
        wr(IRQC_EOI, 16'h0000);

        wr(IRQC_MASK, 16'h0000);
        pulse(8'h08);
        rd(IRQC_PEND, 16'h0008, "t3_pend_masked");
        ck_irq(0, "t3_irq_masked");
        wr(IRQC_MASK, 16'h0008);
        ck_irq(1, "t3_irq_unmasked");
        wr(IRQC_PEND, 16'h0008);
        ck_irq(0, "t3_irq_after_w1c");
        rd(IRQC_PEND, 16'h0000, "t3_pend_w1c");

        ien = 0;
        pulse(8'h08);
        ck_irq(0, "t4_irq_ien_off");
        fetch();
        rd(IRQC_VEC,  16'h0005, "t4_no_accept_vec");
        rd(IRQC_PEND, 16'h0008, "t4_no_accept_pend");
        ien = 1;
        ck_irq(1, "t4_irq_ien_on");
        wr(IRQC_PEND, 16'h0008);

        src = 8'h01;
        ticks(LAT);
        wr(IRQC_PEND, 16'h0001);
        rd(IRQC_PEND, 16'h0001, "t5_set_beats_w1c");
        wr(IRQC_PEND, 16'h0001);
        ticks(3);
        rd(IRQC_PEND, 16'h0000, "t5_held_no_repend");
        src = 0;
        tick();

        wr(IRQC_MASK, 16'h00FF);
        pulse(8'h10);
        fetch();
        pulse(8'h40);
        ck_irq(0, "t6_no_nesting");
        rd(IRQC_PEND, 16'h0040, "t6_pend_during_svc");
        rd(IRQC_VEC,  16'h8004, "t6_vec");
        rst_n = 0;
        ck_irq(0, "t6_rst_irq_imm");
        rd(IRQC_VEC,  16'h0000, "t6_rst_vec_imm");
        rd(IRQC_PEND, 16'h0000, "t6_rst_pend");
        rd(IRQC_MASK, 16'h0000, "t6_rst_mask");
        rst_n = 1;
        tick();
        ck_irq(0, "t6_post_irq");
        rd(IRQC_MASK, 16'h0000, "t6_post_mask");
        rd(IRQC_PEND, 16'h0000, "t6_post_pend");
        rd(IRQC_VEC,  16'h0000, "t6_post_vec");

        ticks(2);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
